// File: rtl/gear_pkg.sv
// Shared types and helpers for the GeAr approximate adder with serial correction.
package gear_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORR = 2'd1,
      DONE = 2'd2
   } gear_state_t;

   // Number of sub-adders: one full-width low adder plus one per R-bit upper slice.
   function automatic int gear_k(input int n, input int r, input int p);
      if (r < 1) return 1;
      return 1 + (n - (r + p)) / r;
   endfunction

endpackage

// File: rtl/gear_slice_adder.sv
// Combinational W-bit adder with carry-in and carry-out, used for one correction slice.
module gear_slice_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   assign s    = full[W-1:0];
   assign co   = full[W];

endmodule

// File: rtl/gear_corrector.sv
// GeAr approximate adder: speculative sum at acceptance, then optional
// slice-by-slice exact correction with a per-slice error mask.
module gear_corrector
   import gear_pkg::*;
#(
   parameter int N = 32,
   parameter int R = 8,
   parameter int P = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic [N-1:0]              i_a,
   input  logic [N-1:0]              i_b,
   input  logic                      i_exact,
   input  logic                      i_valid,
   output logic                      o_ready,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [N-1:0]              o_sum,
   output logic [gear_k(N,R,P)-1:0]  o_err_mask,
   output logic                      o_err
);

   localparam int L  = R + P;
   localparam int K  = gear_k(N, R, P);
   localparam int CW = $clog2(K + 1);

   if (N < L || R < 1 || P < 0 || ((N - L) % R) != 0) begin : g_bad_params
      $error("gear_corrector: illegal N/R/P combination");
   end

   // Handshake: operands are taken on i_valid & o_ready (IDLE only); the result
   // is held on o_valid in DONE until i_ready, and nothing is accepted that cycle.
   gear_state_t     state_q;
   logic [CW-1:0]   cnt_q;
   logic [N-1:0]    a_q;
   logic [N-1:0]    b_q;
   logic            carry_q;
   logic [N-1:0]    sum_q;
   logic [K-1:0]    mask_q;

   logic [N-1:0]    approx;
   logic [L:0]      low_sum;

   assign low_sum        = {1'b0, i_a[L-1:0]} + {1'b0, i_b[L-1:0]};
   assign approx[L-1:0]  = low_sum[L-1:0];

   // Each upper sub-adder sees P lower bits of prediction and keeps only its top R bits.
   for (genvar j = 1; j < K; j++) begin : g_spec
      logic [L-1:0] s;
      assign s                  = i_a[j*R +: L] + i_b[j*R +: L];
      assign approx[P+j*R +: R] = s[L-1:P];
   end

   logic [R-1:0] sl_a;
   logic [R-1:0] sl_b;
   logic [R-1:0] sl_old;
   logic [R-1:0] sl_s;
   logic         sl_co;

   always_comb begin
      sl_a   = '0;
      sl_b   = '0;
      sl_old = '0;
      for (int j = 1; j < K; j++) begin
         if (cnt_q == CW'(j)) begin
            sl_a   = a_q[P+j*R +: R];
            sl_b   = b_q[P+j*R +: R];
            sl_old = sum_q[P+j*R +: R];
         end
      end
   end

   gear_slice_adder #(.W(R)) u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         mask_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  a_q     <= i_a;
                  b_q     <= i_b;
                  sum_q   <= approx;
                  carry_q <= low_sum[L];
                  mask_q  <= '0;
                  cnt_q   <= CW'(1);
                  state_q <= (i_exact && (K > 1)) ? CORR : DONE;
               end
            end
            CORR: begin
               for (int j = 1; j < K; j++) begin
                  if (cnt_q == CW'(j)) begin
                     sum_q[P+j*R +: R] <= sl_s;
                     mask_q[j]         <= (sl_s != sl_old);
                  end
               end
               carry_q <= sl_co;
               if (cnt_q == CW'(K - 1)) state_q <= DONE;
               else                     cnt_q   <= cnt_q + 1'b1;
            end
            DONE: begin
               if (i_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_ready    = (state_q == IDLE);
   assign o_valid    = (state_q == DONE);
   assign o_sum      = sum_q;
   assign o_err_mask = mask_q;
   assign o_err      = |mask_q;

endmodule

// File: doc/gear_corrector.md
GEAR_CORRECTOR -- requirements
Module: gear_corrector

Interface
REQ-001 The block SHALL have parameter N, default 32: operand and sum width in bits.
REQ-002 The block SHALL have parameter R, default 8: result bits contributed by each upper sub-adder.
REQ-003 The block SHALL have parameter P, default 8: overlap (prediction) bits per sub-adder; derived L = R+P, K = 1+(N-L)/R.
REQ-004 The block SHALL have port i_clk, input, 1: single clock, all state on rising edge.
REQ-005 The block SHALL have port i_rstn, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port i_a, input, N: first operand.
REQ-007 The block SHALL have port i_b, input, N: second operand.
REQ-008 The block SHALL have port i_exact, input, 1: 1 = corrected (exact) sum, 0 = approximate GeAr sum only.
REQ-009 The block SHALL have port i_valid, input, 1: operands valid.
REQ-010 The block SHALL have port o_ready, output, 1: block can accept operands.
REQ-011 The block SHALL have port o_valid, output, 1: result valid.
REQ-012 The block SHALL have port i_ready, input, 1: downstream accepts result.
REQ-013 The block SHALL have port o_sum, output, N: result, modulo 2^N.
REQ-014 The block SHALL have port o_err_mask, output, K: bit j set = upper sub-adder j approximate slice differed from exact.
REQ-015 The block SHALL have port o_err, output, 1: OR-reduction of o_err_mask.

Function
REQ-016 Elaboration SHALL fail unless N >= L, R >= 1, P >= 0 and (N-L) mod R == 0.
REQ-017 Approximate sum SHALL be: bits [L-1:0] = low L bits of a[L-1:0]+b[L-1:0]; for j=1..K-1, bits [P+jR +: R] = bits [L-1:P] of a[jR +: L]+b[jR +: L], carry-in 0.
REQ-018 Exact sum SHALL be (a+b) mod 2^N, built as slice 0 = a[L-1:0]+b[L-1:0] with carry c_1 = its bit L; slice j = a[P+jR +: R]+b[P+jR +: R]+c_j, c_{j+1} = carry out.
REQ-019 FSM states SHALL be IDLE, CORR, DONE; o_ready = (state==IDLE).
REQ-020 Acceptance SHALL occur when i_valid & o_ready; block captures i_a, i_b, i_exact, approximate sum, slice 0 and c_1.
REQ-021 IDLE SHALL go to CORR on acceptance if i_exact=1 and K>1, else to DONE; otherwise stay.
REQ-022 CORR SHALL process exactly one slice per cycle, j = 1..K-1 via a counter, writing exact slice j into the result register and setting o_err_mask[j] if it differs from the approximate slice j.
REQ-023 CORR SHALL go to DONE after slice K-1 is processed.
REQ-024 Latency SHALL be: o_valid rises 1 cycle after acceptance in approximate mode, K cycles after acceptance in exact mode.
REQ-025 In DONE, o_valid=1 and o_sum, o_err_mask, o_err SHALL be stable until i_ready=1, then return to IDLE next cycle; no new acceptance in the DONE-to-IDLE cycle.
REQ-026 In approximate mode o_sum SHALL be the approximate sum, o_err_mask all zeros.
REQ-027 o_err_mask[0] SHALL always be 0; carry out of bit N-1 SHALL be discarded.
REQ-028 i_a, i_b, i_exact SHALL be ignored outside the acceptance cycle.

Reset
REQ-029 When i_rstn=0 at a clock edge, state SHALL become IDLE and the counter, o_valid, o_sum, o_err_mask, o_err SHALL become 0.
REQ-030 Reset asserted in CORR or DONE SHALL discard the operation with no result; o_ready=1 the cycle after reset deasserts.

Structure
REQ-031 Package gear_pkg SHALL hold the FSM state enum and a function computing K from N, R, P.
REQ-032 A sub-module gear_slice_adder (R-bit adder with carry-in/carry-out, combinational) SHALL be used for CORR slice computation.

Verification (R=8, P=8, N=32, K=3)
REQ-033 a=0x0000FFFF, b=0x1, exact -> o_sum=0x00010000, mask=0b010, o_err=1, o_valid 3 cycles after accept.
REQ-034 Same operands, approximate -> o_sum=0x00000000, mask=0, o_valid 1 cycle after accept.
REQ-035 a=0x00FFFFFF, b=0x1, exact -> o_sum=0x01000000, mask=0b110; approximate -> 0x00FF0000.
REQ-036 a=0xFFFFFFFF, b=0x1, exact -> o_sum=0x00000000, mask=0b110 (wrap-around).
REQ-037 Exact op with i_ready held 0 for 5 cycles -> o_valid and outputs stable, o_ready=0; i_ready=1 -> IDLE next cycle.
REQ-038 i_rstn=0 during CORR -> next cycle IDLE, o_valid=0, o_sum=0; a following op completes normally.
